serial_sub_16bit: RTL

SERIAL_SUB_16BIT -- requirements
Module: serial_sub_16bit

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/subtractor_1bit.sv | 13 +
 rtl/serial_sub_16bit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int SUB_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_e;

endpackage

// File: rtl/subtractor_1bit.sv
// One-bit full subtractor: diff = a - b - borrow_in, with borrow out.
module subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_sub_16bit.sv
// Bit-serial subtractor, LSB first, one bit per cycle through a single subtractor_1bit.
// Define SERIAL_SUB_ASSERT_EN to compile simulation-only operand/result checks.
module serial_sub_16bit
  import serial_sub_pkg::*;
#(
  parameter int NUM_BITS = SUB_W_DEFAULT
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                borrow_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] diff,
  output logic                underflow
);

  localparam int CW = $clog2(NUM_BITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

  sub_state_e          r_state;
  sub_state_e          w_next;
  logic [NUM_BITS-1:0] r_a;
  logic [NUM_BITS-1:0] r_b;
  logic                r_br;
  logic [NUM_BITS-1:0] r_res;
  logic [CW-1:0]       r_cnt;
  logic [NUM_BITS-1:0] r_diff;
  logic                r_uf;

  logic                w_d;
  logic                w_bout;
  logic                w_accept;
  logic                w_last;
  logic [NUM_BITS-1:0] w_res_nxt;

`ifdef SERIAL_SUB_ASSERT_EN
  logic [NUM_BITS-1:0] r_ca;
  logic [NUM_BITS-1:0] r_cb;
  logic                r_cbr;
`endif

  subtractor_1bit u_bit (
    .a          (r_a[0]),
    .b          (r_b[0]),
    .borrow_in  (r_br),
    .diff       (w_d),
    .borrow_out (w_bout)
  );

  // start is only honoured outside SHIFT; a running operation cannot be relatched.
  assign w_accept  = start && (r_state != SHIFT);
  assign w_last    = (r_state == SHIFT) && (r_cnt == LAST);
  assign w_res_nxt = {w_d, r_res[NUM_BITS-1:1]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (r_cnt == LAST) w_next = DONE;
      DONE:    w_next = start ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_br    <= 1'b0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_uf    <= 1'b0;
`ifdef SERIAL_SUB_ASSERT_EN
      r_ca    <= '0;
      r_cb    <= '0;
      r_cbr   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_br  <= borrow_in;
        r_cnt <= '0;
`ifdef SERIAL_SUB_ASSERT_EN
        r_ca  <= a;
        r_cb  <= b;
        r_cbr <= borrow_in;
`endif
      end else if (r_state == SHIFT) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_br  <= w_bout;
        r_res <= w_res_nxt;
        r_cnt <= r_cnt + 1'b1;
        // The final bit goes straight into the output, so diff is valid in the DONE cycle.
        if (w_last) begin
          r_diff <= w_res_nxt;
          r_uf   <= w_bout;
        end
      end
    end
  end

  assign busy      = (r_state == SHIFT);
  assign done      = (r_state == DONE);
  assign diff      = r_diff;
  assign underflow = r_uf;

`ifdef SERIAL_SUB_ASSERT_EN
  logic [NUM_BITS:0] w_ref;
  assign w_ref = {1'b0, r_ca} - {1'b0, r_cb} - {{NUM_BITS{1'b0}}, r_cbr};

  always @(posedge clk) begin
    if (n_rst && w_accept)
      assert (!$isunknown({a, b, borrow_in}))
        else $error("serial_sub: unknown operand at start");
    if (n_rst && done)
      assert ({r_uf, r_diff} == w_ref)
        else $error("serial_sub: result %h differs from reference %h", {r_uf, r_diff}, w_ref);
  end
`endif

endmodule
